// File: rtl/disp_driver.sv
// disp_driver: reader side of the register-file display tap.
// Converts the 16-bit DIS word into hex or unsigned-decimal digits and
// drives a 4-digit, common-anode, multiplexed 7-segment display.
//
// Ports:
//   CLK   system clock, all logic on rising edge
//   RST   synchronous active-high reset
//   DIS   value to display (register 15 contents)
//   MODE  0 = hex, 1 = unsigned decimal
//   AN    digit anodes, active-low one-hot, AN[0] = rightmost digit
//   SEG   segments {g,f,e,d,c,b,a}, active-low
//   DP    decimal point, active-low, always off
//   BUSY  high while the conversion FSM is not idle
module disp_driver #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          LZB         = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DIS,
  input  logic        MODE,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        BUSY
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t        state;
  logic          dirty;
  logic [15:0]   snap;
  logic          smode;
  logic [15:0]   shown_val;
  logic          shown_mode;
  logic [19:0]   bcd;
  logic [3:0]    bit_cnt;
  logic [15:0]   dig;      // four 4-bit digit registers, digit 0 in [3:0]
  logic [3:0]    blank;
  logic          dash;
  logic [CW-1:0] ref_cnt;
  logic [1:0]    sel;

  logic [15:0]   bcd_adj;
  logic [3:0]    dec_blank;
  logic [6:0]    seg_now;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Ten-thousands nibble never reaches 5 before a shift for a 16-bit
  // input (max 3 before the final shift), so only the low four nibbles
  // need the add-3 correction.
  always_comb begin
    bcd_adj = bcd[15:0];
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Leading-zero blanking: a digit is blank when it and everything to its
  // left are zero; digit 0 always shows.
  always_comb begin
    dec_blank    = '0;
    dec_blank[3] = LZB && (bcd[15:12] == 4'd0);
    dec_blank[2] = dec_blank[3] && (bcd[11:8] == 4'd0);
    dec_blank[1] = dec_blank[2] && (bcd[7:4] == 4'd0);
  end

  always_comb begin
    if (dash)
      seg_now = 7'h3F;
    else if (blank[sel])
      seg_now = 7'h7F;
    else
      seg_now = hex7(dig[{sel, 2'b00} +: 4]);
  end

  // Conversion FSM
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      dirty      <= 1'b1;
      snap       <= '0;
      smode      <= 1'b0;
      shown_val  <= '0;
      shown_mode <= 1'b0;
      bcd        <= '0;
      bit_cnt    <= '0;
      dig        <= '0;
      blank      <= '0;
      dash       <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dirty || (DIS != shown_val) || (MODE != shown_mode)) begin
            snap    <= DIS;
            smode   <= MODE;
            dirty   <= 1'b0;
            BUSY    <= 1'b1;
            bcd     <= '0;
            bit_cnt <= '0;
            state   <= MODE ? CONV : LOAD;
          end
        end
        CONV: begin
          bcd     <= {bcd[18:16], bcd_adj, snap[4'd15 - bit_cnt]};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15)
            state <= LOAD;
        end
        LOAD: begin
          if (!smode) begin
            dig   <= snap;
            blank <= '0;
            dash  <= 1'b0;
          end else begin
            dig   <= bcd[15:0];
            dash  <= (bcd[19:16] != 4'd0);
            blank <= (bcd[19:16] != 4'd0) ? 4'b0000 : dec_blank;
          end
          shown_val  <= snap;
          shown_mode <= smode;
          BUSY       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Refresh multiplexer; AN and SEG register from the same select value
  always_ff @(posedge CLK) begin
    if (RST) begin
      ref_cnt <= '0;
      sel     <= '0;
      AN      <= 4'hF;
      SEG     <= 7'h7F;
      DP      <= 1'b1;
    end else begin
      if (ref_cnt == REF_LAST) begin
        ref_cnt <= '0;
        sel     <= sel + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      AN  <= ~(4'b0001 << sel);
      SEG <= seg_now;
      DP  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_disp_driver.sv
// Bench for disp_driver: two instances (leading-zero blanking on and off)
// share all inputs; a scoreboard queue holds the expected display for
// every conversion that should complete, and a monitor compares the
// scanned-out digits after each load.
module tb_disp_driver;

  localparam int unsigned RD = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] DIS = 16'h1A2F;
  logic        MODE = 1'b0;

  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, busy_a, busy_b;

  always #5 CLK = ~CLK;

  disp_driver #(.REFRESH_DIV(RD), .LZB(1'b1)) dut (
    .CLK(CLK), .RST(RST), .DIS(DIS), .MODE(MODE),
    .AN(an_a), .SEG(seg_a), .DP(dp_a), .BUSY(busy_a)
  );

  disp_driver #(.REFRESH_DIV(RD), .LZB(1'b0)) dut_nb (
    .CLK(CLK), .RST(RST), .DIS(DIS), .MODE(MODE),
    .AN(an_b), .SEG(seg_b), .DP(dp_b), .BUSY(busy_b)
  );

  typedef struct {
    logic [27:0] lz;
    logic [27:0] nz;
    int          width;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] sv = 16'h0;
  logic        sm = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // 0-15 hex glyphs, 16 = dash, 17 = blank
  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; 15: return 7'h0E;
      16: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [27:0] model(input logic [15:0] v, input logic m, input bit lzb);
    logic [27:0] r;
    int val, p, d;
    val = int'(v);
    p = 1;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (!m) d = (val >> (4 * i)) & 15;
      else if (val > 9999) d = 16;
      else if (i > 0 && lzb && val < p) d = 17;
      else d = (val / p) % 10;
      r[7*i +: 7] = seg_code(d);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic push(input logic [15:0] v, input logic m);
    exp_t e;
    e.lz = model(v, m, 1'b1);
    e.nz = model(v, m, 1'b0);
    e.width = m ? 17 : 1;
    q.push_back(e);
    sv = v;
    sm = m;
  endtask

  task automatic drive(input logic [15:0] v, input logic m);
    @(posedge CLK); #2;
    DIS = v;
    MODE = m;
    push(v, m);
  endtask

  // Cycles until BUSY has been seen high and then low again
  task automatic wait_done(output int lat);
    bit seen;
    seen = busy_a;
    lat = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge CLK); #1;
      lat++;
      if (busy_a) seen = 1'b1;
      else if (seen) return;
    end
    n_checks++;
    $display("FAIL wait_done: conversion not finished after %0d cycles", lat);
    lat = -1;
  endtask

  task automatic hold();
    repeat (4 * RD + 4) @(posedge CLK);
  endtask

  // Monitor: on each completed load pop one expectation and scan a full
  // refresh frame from both instances.
  bit          m_prev = 1'b0;
  int          m_blen = 0;
  int          m_scan = 0;
  logic [6:0]  ca[4];
  logic [6:0]  cb[4];
  int          cnt[4];
  exp_t        cur;

  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        m_prev = 1'b0;
        m_blen = 0;
        m_scan = 0;
        continue;
      end
      if (m_scan > 0) begin
        int idx;
        case (an_a)
          4'b1110: idx = 0;
          4'b1101: idx = 1;
          4'b1011: idx = 2;
          4'b0111: idx = 3;
          default: idx = -1;
        endcase
        if (idx < 0) begin
          n_checks++;
          $display("FAIL an_onehot: got %b expected one low bit", an_a);
        end else begin
          ca[idx] = seg_a;
          cb[idx] = seg_b;
          cnt[idx]++;
        end
        m_scan--;
        if (m_scan == 0) begin
          for (int i = 0; i < 4; i++) begin
            check($sformatf("seg_lzb1_d%0d", i), int'(ca[i]), int'(cur.lz[7*i +: 7]));
            check($sformatf("seg_lzb0_d%0d", i), int'(cb[i]), int'(cur.nz[7*i +: 7]));
            check($sformatf("lit_cycles_d%0d", i), cnt[i], RD);
          end
          check("dp_off", int'(dp_a & dp_b), 1);
        end
      end
      if (busy_a) begin
        m_blen++;
      end else if (m_prev) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_load: got load with empty scoreboard, expected none");
        end else begin
          cur = q.pop_front();
          check("busy_width", m_blen, cur.width);
          for (int i = 0; i < 4; i++) begin
            ca[i] = 7'h55;
            cb[i] = 7'h55;
            cnt[i] = 0;
          end
          m_scan = 4 * RD;
        end
        m_blen = 0;
      end
      m_prev = busy_a;
    end
  end

  initial begin
    int lat;
    logic [15:0] v;
    logic        m;

    repeat (3) @(posedge CLK); #1;
    check("rst_an", int'(an_a), 'hF);
    check("rst_seg", int'(seg_a), 'h7F);
    check("rst_busy", int'(busy_a), 0);
    check("rst_dp", int'(dp_a), 1);
    #1 RST = 1'b0;
    push(16'h1A2F, 1'b0);
    @(posedge CLK); #1;
    check("first_an", int'(an_a), 'hE);
    check("forced_busy", int'(busy_a), 1);
    wait_done(lat);
    hold();

    drive(16'h04D2, 1'b1); wait_done(lat); check("lat_dec", lat, 18); hold();
    drive(16'h0007, 1'b1); wait_done(lat); hold();
    drive(16'h2710, 1'b1); wait_done(lat); hold();
    drive(16'hFFFF, 1'b1); wait_done(lat); hold();
    drive(16'h270F, 1'b1); wait_done(lat); hold();
    drive(16'h0000, 1'b1); wait_done(lat); hold();
    drive(16'hBEEF, 1'b0); wait_done(lat); check("lat_hex", lat, 2); hold();

    // Input change in the middle of a conversion
    drive(16'h0064, 1'b1);
    repeat (6) @(posedge CLK); #2;
    DIS = 16'h00C8;
    push(16'h00C8, 1'b1);
    wait_done(lat);
    @(posedge CLK); #1;
    check("busy_reassert", int'(busy_a), 1);
    wait_done(lat);
    hold();

    // Reset during a conversion
    drive(16'h1F40, 1'b1);
    repeat (9) @(posedge CLK); #2;
    RST = 1'b1;
    @(posedge CLK); #1;
    check("midrst_an", int'(an_a), 'hF);
    check("midrst_seg", int'(seg_a), 'h7F);
    check("midrst_busy", int'(busy_a), 0);
    #1 RST = 1'b0;
    @(posedge CLK); #1;
    check("midrst_first_an", int'(an_a), 'hE);
    check("midrst_forced_busy", int'(busy_a), 1);
    wait_done(lat);
    hold();

    // Mode toggle with DIS constant
    drive(16'h1F40, 1'b0); wait_done(lat); hold();
    drive(16'h1F40, 1'b1); wait_done(lat); hold();

    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 3))
        0: v = 16'($urandom_range(0, 9));
        1: v = 16'($urandom_range(10, 9999));
        2: v = 16'($urandom_range(10000, 65535));
        default: v = 16'($urandom);
      endcase
      m = 1'($urandom_range(0, 1));
      if (v == sv && m == sm) v = v ^ 16'h0001;
      drive(v, m);
      wait_done(lat);
      check("lat_rand", lat, m ? 18 : 2);
      hold();
    end

    repeat (10) @(posedge CLK);
    check("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
